// File: rtl/game_pkg.sv
// Shared definitions for the game controller and the blocks that consume
// its level/lives outputs (enemies, textbox).
//   - state_e  : 3-bit encoded game state, also exported on state_out
//   - *_W      : widths of level, lives and frame counter
//   - *_DEF    : default values for the game_ctrl parameters
package game_pkg;
  localparam int LEVEL_W = 4;
  localparam int LIVES_W = 2;
  localparam int FRAME_W = 8;

  localparam int START_LEVEL_DEF  = 1;
  localparam int MAX_LEVEL_DEF    = 4;
  localparam int LIVES_INIT_DEF   = 3;
  localparam int CLEAR_FRAMES_DEF = 120;
  localparam int HIT_FRAMES_DEF   = 60;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PLAY        = 3'd1,
    ST_LEVEL_CLEAR = 3'd2,
    ST_HIT         = 3'd3,
    ST_GAME_OVER   = 3'd4,
    ST_WIN         = 3'd5
  } state_e;
endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with optional 2-flop synchronizer.
//   clk, rst_n : clock, async active-low reset
//   d          : input level (asynchronous when SYNC=1)
//   rise       : one-cycle pulse on a rising edge of d
// With SYNC=1 the detector is only armed after the synchronized input has
// been seen low, so a button held through reset release produces no edge
// until it is released and pressed again.
module edge_detect #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  generate
    if (SYNC) begin : g_sync
      logic [1:0] sync_q, sync_d;
      logic [1:0] vld_pipe_q, vld_pipe_d;  // marks sync stages holding real samples
      logic       prev_q, prev_d;
      logic       armed_q, armed_d;

      always_comb begin
        sync_d     = {sync_q[0], d};
        vld_pipe_d = {vld_pipe_q[0], 1'b1};
        prev_d     = sync_q[1];
        armed_d    = armed_q | (vld_pipe_q[1] & ~sync_q[1]);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q     <= '0;
          vld_pipe_q <= '0;
          prev_q     <= 1'b0;
          armed_q    <= 1'b0;
        end else begin
          sync_q     <= sync_d;
          vld_pipe_q <= vld_pipe_d;
          prev_q     <= prev_d;
          armed_q    <= armed_d;
        end
      end

      assign rise = sync_q[1] & ~prev_q & armed_q;
    end else begin : g_raw
      logic prev_q, prev_d;

      always_comb prev_d = d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
      end

      assign rise = d & ~prev_q;
    end
  endgenerate
endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: IDLE -> PLAY -> LEVEL_CLEAR / HIT -> ... -> WIN or
// GAME_OVER, paced by frame ticks from vsync.
//   pclk, rst       : pixel clock, async active-low reset
//   vsync_in        : VGA vsync; rising edge is the frame tick
//   fire_btn        : raw start/fire button (asynchronous)
//   ship_hit        : one-cycle pulse, ship struck
//   enemies_cleared : level-sensitive, formation destroyed
//   level, lives    : current level / remaining lives
//   play_en         : high only in PLAY
//   level_start     : one-cycle pulse, reload enemy formation
//   respawn         : one-cycle pulse, recentre ship
//   state_out       : encoded state (game_pkg::state_e)
module game_ctrl
  import game_pkg::*;
#(
  parameter int START_LEVEL  = START_LEVEL_DEF,
  parameter int MAX_LEVEL    = MAX_LEVEL_DEF,
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int CLEAR_FRAMES = CLEAR_FRAMES_DEF,
  parameter int HIT_FRAMES   = HIT_FRAMES_DEF
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync_in,
  input  logic               fire_btn,
  input  logic               ship_hit,
  input  logic               enemies_cleared,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               play_en,
  output logic               level_start,
  output logic               respawn,
  output logic [2:0]         state_out
);
  logic btn_edge, frame_tick;

  edge_detect #(.SYNC(1'b1)) u_btn (
    .clk(pclk), .rst_n(rst), .d(fire_btn), .rise(btn_edge)
  );

  edge_detect #(.SYNC(1'b0)) u_vsync (
    .clk(pclk), .rst_n(rst), .d(vsync_in), .rise(frame_tick)
  );

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               play_en_q, play_en_d;
  logic               level_start_q, level_start_d;
  logic               respawn_q, respawn_d;

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    lives_d       = lives_q;
    frame_d       = frame_q;
    level_start_d = 1'b0;
    respawn_d     = 1'b0;

    if ((state_q == ST_LEVEL_CLEAR || state_q == ST_HIT) && frame_tick)
      frame_d = frame_q + FRAME_W'(1);

    case (state_q)
      ST_IDLE: if (btn_edge) begin
        state_d       = ST_PLAY;
        level_d       = LEVEL_W'(START_LEVEL);
        lives_d       = LIVES_W'(LIVES_INIT);
        level_start_d = 1'b1;
        respawn_d     = 1'b1;
      end
      ST_PLAY: begin
        // ship_hit wins over a simultaneous enemies_cleared
        if (ship_hit) begin
          if (lives_q <= LIVES_W'(1)) begin
            state_d = ST_GAME_OVER;
            lives_d = '0;
          end else begin
            state_d = ST_HIT;
            lives_d = lives_q - LIVES_W'(1);
          end
        end else if (enemies_cleared) begin
          state_d = (level_q >= LEVEL_W'(MAX_LEVEL)) ? ST_WIN : ST_LEVEL_CLEAR;
        end
      end
      ST_LEVEL_CLEAR: if (frame_tick && frame_q == FRAME_W'(CLEAR_FRAMES - 1)) begin
        state_d       = ST_PLAY;
        if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
        level_start_d = 1'b1;
        respawn_d     = 1'b1;
      end
      ST_HIT: if (frame_tick && frame_q == FRAME_W'(HIT_FRAMES - 1)) begin
        state_d   = ST_PLAY;
        respawn_d = 1'b1;
      end
      ST_GAME_OVER, ST_WIN: if (btn_edge) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // every state entry restarts the frame count
    if (state_d != state_q) frame_d = '0;
    play_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      level_q       <= LEVEL_W'(START_LEVEL);
      lives_q       <= LIVES_W'(LIVES_INIT);
      frame_q       <= '0;
      play_en_q     <= 1'b0;
      level_start_q <= 1'b0;
      respawn_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      frame_q       <= frame_d;
      play_en_q     <= play_en_d;
      level_start_q <= level_start_d;
      respawn_q     <= respawn_d;
    end
  end

  assign level       = level_q;
  assign lives       = lives_q;
  assign play_en     = play_en_q;
  assign level_start = level_start_q;
  assign respawn     = respawn_q;
  assign state_out   = state_q;
endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_LC = 3'd2,
                         S_HIT = 3'd3, S_GO = 3'd4, S_WIN = 3'd5;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       vsync_in = 1'b0;
  logic       fire_btn = 1'b0;
  logic       ship_hit = 1'b0;
  logic       enemies_cleared = 1'b0;
  logic [3:0] level;
  logic [1:0] lives;
  logic       play_en, level_start, respawn;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_err = 0;

  game_ctrl dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .fire_btn(fire_btn),
    .ship_hit(ship_hit), .enemies_cleared(enemies_cleared),
    .level(level), .lives(lives), .play_en(play_en),
    .level_start(level_start), .respawn(respawn), .state_out(state_out)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         frames;
    logic       hit;
    logic       clr;
    logic [2:0] st;
    logic [3:0] lvl;
    logic [1:0] lv;
    logic       pe;
    logic       ls;
    logic       rs;
  } vec_t;

  vec_t tbl[19];

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [2:0] st, logic [3:0] lvl, logic [1:0] lv,
                         logic pe, logic ls, logic rs);
    chk({nm, ".state"}, 8'(state_out), 8'(st));
    chk({nm, ".level"}, 8'(level), 8'(lvl));
    chk({nm, ".lives"}, 8'(lives), 8'(lv));
    chk({nm, ".play_en"}, 8'(play_en), 8'(pe));
    chk({nm, ".level_start"}, 8'(level_start), 8'(ls));
    chk({nm, ".respawn"}, 8'(respawn), 8'(rs));
  endtask

  // n vsync pulses; returns right after the cycle holding the last tick
  task automatic frames(int n);
    for (int k = 0; k < n; k++) begin
      step(); step();
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
    end
  endtask

  task automatic pulse(logic hit, logic clr);
    ship_hit = hit;
    enemies_cleared = clr;
    step();
    ship_hit = 1'b0;
    enemies_cleared = 1'b0;
  endtask

  // press, check edge latency through the synchronizer, then release
  task automatic press(string nm, logic [2:0] pre, logic [2:0] st, logic [3:0] lvl,
                       logic [1:0] lv, logic pe, logic ls, logic rs);
    fire_btn = 1'b1;
    step(); step();
    chk({nm, ".pre"}, 8'(state_out), 8'(pre));
    step();
    chk_all(nm, st, lvl, lv, pe, ls, rs);
    fire_btn = 1'b0;
    step();
    chk({nm, ".ls_off"}, 8'(level_start), 8'd0);
    chk({nm, ".rs_off"}, 8'(respawn), 8'd0);
    step(); step();
  endtask

  initial begin
    //             frames hit clr  state  lvl lv pe ls rs
    tbl[0]  = '{0,   0, 0, S_PLAY, 1, 3, 1, 0, 0};
    tbl[1]  = '{0,   0, 1, S_LC,   1, 3, 0, 0, 0};
    tbl[2]  = '{119, 0, 0, S_LC,   1, 3, 0, 0, 0};
    tbl[3]  = '{1,   0, 0, S_PLAY, 2, 3, 1, 1, 1};
    tbl[4]  = '{0,   0, 0, S_PLAY, 2, 3, 1, 0, 0};
    tbl[5]  = '{0,   1, 0, S_HIT,  2, 2, 0, 0, 0};
    tbl[6]  = '{0,   0, 1, S_HIT,  2, 2, 0, 0, 0};
    tbl[7]  = '{59,  0, 0, S_HIT,  2, 2, 0, 0, 0};
    tbl[8]  = '{1,   0, 0, S_PLAY, 2, 2, 1, 0, 1};
    tbl[9]  = '{0,   1, 1, S_HIT,  2, 1, 0, 0, 0};
    tbl[10] = '{60,  0, 0, S_PLAY, 2, 1, 1, 0, 1};
    tbl[11] = '{0,   0, 1, S_LC,   2, 1, 0, 0, 0};
    tbl[12] = '{0,   1, 0, S_LC,   2, 1, 0, 0, 0};
    tbl[13] = '{120, 0, 0, S_PLAY, 3, 1, 1, 1, 1};
    tbl[14] = '{0,   0, 1, S_LC,   3, 1, 0, 0, 0};
    tbl[15] = '{120, 0, 0, S_PLAY, 4, 1, 1, 1, 1};
    tbl[16] = '{0,   0, 1, S_WIN,  4, 1, 0, 0, 0};
    tbl[17] = '{0,   1, 0, S_WIN,  4, 1, 0, 0, 0};
    tbl[18] = '{0,   1, 1, S_WIN,  4, 1, 0, 0, 0};

    // reset state
    step();
    chk_all("reset", S_IDLE, 1, 3, 0, 0, 0);
    pulse(1'b1, 1'b1);
    chk_all("idle_ignore", S_IDLE, 1, 3, 0, 0, 0);
    rst = 1'b1;
    repeat (4) step();

    press("start", S_IDLE, S_PLAY, 1, 3, 1, 1, 1);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].frames > 0) frames(tbl[i].frames);
      else pulse(tbl[i].hit, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].lvl, tbl[i].lv,
              tbl[i].pe, tbl[i].ls, tbl[i].rs);
    end

    // WIN -> IDLE keeps level/lives, then a fresh game
    press("win_idle", S_WIN, S_IDLE, 4, 1, 0, 0, 0);
    press("restart", S_IDLE, S_PLAY, 1, 3, 1, 1, 1);

    // three hits separated by full HIT periods
    pulse(1'b1, 1'b0);
    chk_all("hit1", S_HIT, 1, 2, 0, 0, 0);
    frames(60);
    chk_all("hit1_end", S_PLAY, 1, 2, 1, 0, 1);
    pulse(1'b1, 1'b0);
    chk_all("hit2", S_HIT, 1, 1, 0, 0, 0);
    frames(60);
    chk_all("hit2_end", S_PLAY, 1, 1, 1, 0, 1);
    pulse(1'b1, 1'b0);
    chk_all("hit3", S_GO, 1, 0, 0, 0, 0);
    pulse(1'b1, 1'b1);
    chk_all("go_ignore", S_GO, 1, 0, 0, 0, 0);
    press("go_idle", S_GO, S_IDLE, 1, 0, 0, 0, 0);

    // reset mid LEVEL_CLEAR with button held through release
    press("start2", S_IDLE, S_PLAY, 1, 3, 1, 1, 1);
    pulse(1'b0, 1'b1);
    chk_all("lc2", S_LC, 1, 3, 0, 0, 0);
    frames(50);
    chk_all("lc2_f50", S_LC, 1, 3, 0, 0, 0);
    fire_btn = 1'b1;
    #2 rst = 1'b0;
    #1 chk_all("rst_mid", S_IDLE, 1, 3, 0, 0, 0);
    step();
    rst = 1'b1;
    repeat (8) step();
    chk_all("held_btn", S_IDLE, 1, 3, 0, 0, 0);
    fire_btn = 1'b0;
    repeat (4) step();
    press("repress", S_IDLE, S_PLAY, 1, 3, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter START_LEVEL, default 1: level loaded on game start, range 1..MAX_LEVEL.
REQ-002 Parameter MAX_LEVEL, default 4: final level; clearing it wins the game.
REQ-003 Parameter LIVES_INIT, default 3: lives loaded on game start, range 1..3.
REQ-004 Parameter CLEAR_FRAMES, default 120: frames spent in LEVEL_CLEAR, range 1..255.
REQ-005 Parameter HIT_FRAMES, default 60: frames spent in HIT, range 1..255.
REQ-006 pclk  input  1  pixel clock; sole clock.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 vsync_in  input  1  VGA vsync from the timing chain; its rising edge is the frame tick.
REQ-009 fire_btn  input  1  raw missile/start button; asynchronous to pclk.
REQ-010 ship_hit  input  1  one-cycle pulse: enemy missile struck ship.
REQ-011 enemies_cleared  input  1  level-sensitive: all enemies of the current level destroyed.
REQ-012 level  output  4  current level, to enemies and textbox.
REQ-013 lives  output  2  remaining lives.
REQ-014 play_en  output  1  high only in PLAY; gates ship and enemy motion.
REQ-015 level_start  output  1  one-cycle pulse; reloads the enemy formation.
REQ-016 respawn  output  1  one-cycle pulse; recentres the ship.
REQ-017 state_out  output  3  encoded state, for textbox messages.

Function
REQ-018 fire_btn shall pass a 2-flop synchronizer, then a rising-edge detector producing btn_edge, a one-cycle pulse.
REQ-019 vsync_in shall be registered; frame_tick = vsync_in & ~vsync_q, one cycle per frame.
REQ-020 States: IDLE, PLAY, LEVEL_CLEAR, HIT, GAME_OVER, WIN; all outputs registered.
REQ-021 IDLE: on btn_edge, go to PLAY; load level=START_LEVEL and lives=LIVES_INIT; pulse level_start and respawn in the same cycle PLAY is entered.
REQ-022 PLAY: ship_hit with lives==1 -> GAME_OVER, lives=0; ship_hit with lives>1 -> HIT, lives-1.
REQ-023 PLAY: enemies_cleared with no ship_hit -> WIN if level==MAX_LEVEL, else LEVEL_CLEAR.
REQ-024 Simultaneous ship_hit and enemies_cleared in PLAY: ship_hit shall take priority.
REQ-025 Frame counter, 8 bits: cleared on every state entry; increments on frame_tick only in LEVEL_CLEAR and HIT.
REQ-026 LEVEL_CLEAR: when the counter reaches CLEAR_FRAMES-1 and frame_tick is high, go to PLAY with level+1; pulse level_start and respawn.
REQ-027 HIT: when the counter reaches HIT_FRAMES-1 and frame_tick is high, go to PLAY with level unchanged; pulse respawn only.
REQ-028 GAME_OVER, WIN: on btn_edge, go to IDLE; level and lives hold until the next game start.
REQ-029 ship_hit, enemies_cleared and btn_edge shall be ignored in states where they are not listed.
REQ-030 Latency: a qualifying input sampled in cycle N shall be reflected in state_out and the outputs in cycle N+1.
REQ-031 level shall never exceed MAX_LEVEL and lives shall never underflow below 0.

Reset
REQ-032 Asserting rst, including mid-game, shall immediately force state=IDLE, level=START_LEVEL, lives=LIVES_INIT, play_en=0, level_start=0, respawn=0, frame counter=0, and clear the synchronizer and edge registers.
REQ-033 With btn held through reset release, no btn_edge shall be generated until the button is released and pressed again.

Structure
REQ-034 Package game_pkg shall hold the state enum (3-bit encoding), the default parameter constants and the level/lives widths shared with enemies and textbox.
REQ-035 Sub-module edge_detect (2-flop synchronizer plus rising-edge detector) shall be instantiated for fire_btn; vsync_in needs only its edge stage.

Verification
REQ-036 Reset release, btn press -> PLAY next cycle, level=1, lives=3, level_start=1 and respawn=1 for exactly one cycle.
REQ-037 PLAY, enemies_cleared at level 1 -> LEVEL_CLEAR, play_en=0; after exactly 120 vsync rising edges -> PLAY, level=2, level_start pulse.
REQ-038 PLAY, three ship_hit pulses separated by full HIT periods -> lives 2, 1, then GAME_OVER with lives=0; btn press -> IDLE.
REQ-039 ship_hit and enemies_cleared in the same cycle with lives=2 -> HIT, lives=1, level unchanged.
REQ-040 Level 4 enemies_cleared -> WIN; further ship_hit pulses -> no change in state, level or lives.
REQ-041 rst asserted in LEVEL_CLEAR at frame 50 -> IDLE, level=1, lives=3 immediately; btn held through reset release -> no start until released and re-pressed.
